// File: rtl/channel_slicer.sv
// -----------------------------------------------------------------------------
// channel_slicer
//
// Receive-side slicer for the fading channel model. It turns the channel's
// saturating fading level back into the transmitted serial bit stream. The
// direction of the slope gives the bit: a rising level is a 1 and a falling
// level is a 0. A UI phase counter is pulled into line by slope reversals.
// Once the phase is locked, the slicer emits one majority-voted bit per UI.
//
// Optional feature, selected by the macro SLICER_HYST_EN:
//   The slope direction only flips after the level has moved HYST LSBs away
//   from the running extremum. This filters single-LSB glitches. When the
//   macro is undefined, any nonzero step sets the direction and the HYST
//   parameter does not exist.
//
// Ports:
//   faster_clk   in   1        sample clock
//   rst_n        in   1        asynchronous active-low reset
//   level_in     in   LEVEL_W  fading level from the channel
//   level_valid  in   1        level_in is valid this cycle
//   bit_out      out  1        recovered bit, held between strobes
//   bit_valid    out  1        one-cycle strobe, bit_out is valid
//   locked       out  1        phase FSM is in LOCKED
//   slope_dir    out  1        current registered slope decision (debug)
// -----------------------------------------------------------------------------
module channel_slicer #(
   parameter int LEVEL_W      = 10,
   parameter int OSR          = 100,
   parameter int TOL          = 3,
   parameter int LOCK_EDGES   = 4,
   parameter int UNLOCK_EDGES = 2
`ifdef SLICER_HYST_EN
   ,
   parameter int HYST         = 2
`endif
) (
   input  logic               faster_clk,
   input  logic               rst_n,
   input  logic [LEVEL_W-1:0] level_in,
   input  logic               level_valid,
   output logic               bit_out,
   output logic               bit_valid,
   output logic               locked,
   output logic               slope_dir
);

   localparam int PH_W   = $clog2(OSR);
   localparam int ONES_W = $clog2(OSR + 1);
   localparam int GOOD_W = $clog2(LOCK_EDGES + 1);
   localparam int BAD_W  = $clog2(UNLOCK_EDGES + 1);

   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OSR - 1);
   localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(OSR / 2);
   localparam logic [PH_W-1:0]   PH_TOL    = PH_W'(TOL);
   localparam logic [PH_W-1:0]   PH_HI     = PH_W'(OSR - TOL);
   localparam logic [ONES_W-1:0] ONES_HALF = ONES_W'(OSR / 2);
   localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_EDGES);
   localparam logic [BAD_W-1:0]  BAD_MAX   = BAD_W'(UNLOCK_EDGES);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   state_t              state_q, state_d;
   logic                dir_q, dir_d;
   logic [PH_W-1:0]     ph_q, ph_d;
   logic [ONES_W-1:0]   ones_q, ones_d, ones_incl;
   logic [GOOD_W-1:0]   good_q, good_d;
   logic [BAD_W-1:0]    bad_q, bad_d;
   logic                bit_q, bit_valid_q, locked_q;
   logic                edge_det, on_grid, decide, decide_bit, emit;

   // ---------------------------------------------------------------------
   // Slope decision
   // ---------------------------------------------------------------------
`ifdef SLICER_HYST_EN
   localparam logic [LEVEL_W+1:0] HYST_X = (LEVEL_W + 2)'(HYST);

   // Running max while rising, running min while falling. It restarts
   // from the current level on every flip.
   logic [LEVEL_W-1:0] ext_q, ext_d;
   logic [LEVEL_W+1:0] lvl_x, ext_x;

   always_comb begin
      lvl_x = {2'b00, level_in};
      ext_x = {2'b00, ext_q};
      dir_d = dir_q;
      ext_d = ext_q;
      if (dir_q) begin
         if (lvl_x + HYST_X <= ext_x) begin
            dir_d = 1'b0;
            ext_d = level_in;
         end else if (level_in > ext_q) begin
            ext_d = level_in;
         end
      end else begin
         if (lvl_x >= ext_x + HYST_X) begin
            dir_d = 1'b1;
            ext_d = level_in;
         end else if (level_in < ext_q) begin
            ext_d = level_in;
         end
      end
   end

   always_ff @(posedge faster_clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_q <= '0;
      end else if (level_valid) begin
         ext_q <= ext_d;
      end
   end
`else
   logic [LEVEL_W-1:0] level_prev_q;
   logic [LEVEL_W:0]   delta;

   // Both operands are zero-extended, so the top bit of the difference is
   // the sign of the signed delta. A zero delta (including saturation
   // plateaus) holds the previous direction.
   always_comb begin
      delta = {1'b0, level_in} - {1'b0, level_prev_q};
      dir_d = dir_q;
      if (delta[LEVEL_W]) begin
         dir_d = 1'b0;
      end else if (delta != '0) begin
         dir_d = 1'b1;
      end
   end

   always_ff @(posedge faster_clk or negedge rst_n) begin
      if (!rst_n) begin
         level_prev_q <= '0;
      end else if (level_valid) begin
         level_prev_q <= level_in;
      end
   end
`endif

   assign edge_det  = level_valid && (dir_d != dir_q);
   assign on_grid   = (ph_q <= PH_TOL) || (ph_q >= PH_HI);
   assign ones_incl = ones_q + {{(ONES_W-1){1'b0}}, dir_d};

   // ---------------------------------------------------------------------
   // Phase, vote and lock FSM
   // ---------------------------------------------------------------------
   always_comb begin
      ph_d       = ph_q;
      ones_d     = ones_q;
      decide     = 1'b0;
      decide_bit = 1'b0;
      state_d    = state_q;
      good_d     = good_q;
      bad_d      = bad_q;

      if (level_valid) begin
         // An edge takes priority over the end of the window. An edge in the
         // second half closes the partial window with the old direction.
         // An edge in the first half simply discards the partial window.
         if (edge_det) begin
            ph_d   = '0;
            ones_d = '0;
            if (ph_q >= PH_HALF) begin
               decide     = 1'b1;
               decide_bit = dir_q;
            end
         end else if (ph_q == PH_LAST) begin
            ph_d       = '0;
            ones_d     = '0;
            decide     = 1'b1;
            decide_bit = (ones_incl > ONES_HALF);
         end else begin
            ph_d   = ph_q + PH_W'(1);
            ones_d = ones_incl;
         end

         if (edge_det) begin
            case (state_q)
               IDLE: begin
                  state_d = ACQUIRE;
                  good_d  = '0;
               end
               ACQUIRE: begin
                  if (!on_grid) begin
                     good_d = '0;
                  end else if (good_q >= GOOD_MAX - GOOD_W'(1)) begin
                     good_d  = GOOD_MAX;
                     state_d = LOCKED;
                     bad_d   = '0;
                  end else begin
                     good_d = good_q + GOOD_W'(1);
                  end
               end
               LOCKED: begin
                  if (on_grid) begin
                     bad_d = '0;
                  end else if (bad_q >= BAD_MAX - BAD_W'(1)) begin
                     bad_d   = BAD_MAX;
                     state_d = ACQUIRE;
                     good_d  = '0;
                  end else begin
                     bad_d = bad_q + BAD_W'(1);
                  end
               end
               default: begin
                  state_d = IDLE;
               end
            endcase
         end
      end
   end

   // Only emit while LOCKED and staying LOCKED, so the cycle that drops
   // lock never produces a bit.
   assign emit = decide && (state_q == LOCKED) && (state_d == LOCKED);

   always_ff @(posedge faster_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         dir_q       <= 1'b0;
         ph_q        <= '0;
         ones_q      <= '0;
         good_q      <= '0;
         bad_q       <= '0;
         bit_q       <= 1'b0;
         bit_valid_q <= 1'b0;
         locked_q    <= 1'b0;
      end else if (level_valid) begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         ph_q        <= ph_d;
         ones_q      <= ones_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         bit_valid_q <= emit;
         locked_q    <= (state_d == LOCKED);
         if (emit) begin
            bit_q <= decide_bit;
         end
      end else begin
         bit_valid_q <= 1'b0;
      end
   end

   assign bit_out   = bit_q;
   assign bit_valid = bit_valid_q;
   assign locked    = locked_q;
   assign slope_dir = dir_q;

endmodule

// File: tb/tb_channel_slicer.sv
// -----------------------------------------------------------------------------
// tb_channel_slicer
//
// Directed bench for channel_slicer. It builds a channel-like level waveform
// one UI segment at a time, collects every bit_valid strobe, and checks the
// lock behaviour, the recovered bits, the strobe spacing and the reset
// behaviour against hand-computed values.
// -----------------------------------------------------------------------------
module tb_channel_slicer;

   logic       faster_clk = 1'b0;
   logic       rst_n      = 1'b0;
   logic [9:0] level_in   = '0;
   logic       level_valid = 1'b0;
   logic       bit_out, bit_valid, locked, slope_dir;

   // With hysteresis the slow triangle flips one sample after the turn.
`ifdef SLICER_HYST_EN
   localparam int LAG = 1;
`else
   localparam int LAG = 0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int cur_lvl = 0;
   int base_cyc;
   bit got_q[$];
   int strobe_cyc[$];
   logic [19:0] pat = 20'b1111_0101_1100_1000_1010;
   bit exp_bits[$];

   channel_slicer dut (
      .faster_clk  (faster_clk),
      .rst_n       (rst_n),
      .level_in    (level_in),
      .level_valid (level_valid),
      .bit_out     (bit_out),
      .bit_valid   (bit_valid),
      .locked      (locked),
      .slope_dir   (slope_dir)
   );

   always #5 faster_clk = ~faster_clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One sample: drive, clock, then look at the strobe for that sample.
   task automatic step(input int lvl, input logic vld);
      level_in    = 10'(lvl);
      level_valid = vld;
      @(posedge faster_clk);
      #1;
      cyc++;
      if (bit_valid) begin
         got_q.push_back(bit_out);
         strobe_cyc.push_back(cyc);
      end
   endtask

   // Channel-like segment: ramp by stp per sample, saturating at 0 and 255.
   task automatic seg(input bit up, input int len, input int stp);
      for (int i = 0; i < len; i++) begin
         cur_lvl = up ? cur_lvl + stp : cur_lvl - stp;
         if (cur_lvl > 255) cur_lvl = 255;
         if (cur_lvl < 0)   cur_lvl = 0;
         step(cur_lvl, 1'b1);
      end
   endtask

   initial begin
      // Reset values
      #12;
      check("rst_bit_out", int'(bit_out), 0);
      check("rst_bit_valid", int'(bit_valid), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_slope_dir", int'(slope_dir), 0);
      rst_n = 1'b1;

      // Constant zero level: stays idle, never strobes
      repeat (500) step(0, 1'b1);
      repeat (5) step(50, 1'b0);
      check("freeze_dir", int'(slope_dir), 0);
      repeat (500) step(0, 1'b1);
      check("idle_locked", int'(locked), 0);
      check("idle_strobes", got_q.size(), 0);
      check("idle_dir", int'(slope_dir), 0);

      // Alternating triangle: lock on the 4th on-grid edge after the first
      cur_lvl = 0;
      seg(1, 100, 1); seg(0, 100, 1); seg(1, 100, 1); seg(0, 100, 1);
      check("lock_pre", int'(locked), 0);
      seg(1, 1 + LAG, 1);
      check("lock_5th_edge", int'(locked), 1);
      check("lock_no_strobe", got_q.size(), 0);
      seg(1, 99 - LAG, 1);
      got_q.delete(); strobe_cyc.delete();
      seg(0, 100, 1); seg(1, 100, 1); seg(0, 100, 1); seg(1, 100, 1); seg(0, 100, 1);
      check("tri_count", got_q.size(), 5);
      for (int i = 0; i < 5; i++) check($sformatf("tri_bit%0d", i), int'(got_q[i]), (i % 2 == 0) ? 1 : 0);
      for (int i = 1; i < 5; i++) check($sformatf("tri_gap%0d", i), strobe_cyc[i] - strobe_cyc[i-1], 100);

      // Pattern with saturation, then a flushing UI
      got_q.delete();
      for (int i = 19; i >= 16; i--) seg(pat[i], 100, 3);
      check("plateau_dir", int'(slope_dir), 1);
      for (int i = 15; i >= 0; i--) seg(pat[i], 100, 3);
      seg(1, 100, 3);
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 19; i >= 0; i--) exp_bits.push_back(pat[i]);
      check("pat_count", got_q.size(), 21);
      for (int i = 0; i < 21; i++) check($sformatf("pat_bit%0d", i), int'(got_q[i]), int'(exp_bits[i]));

      // Two off-grid edges at ph=50 drop lock
      got_q.delete();
      seg(0, 51, 3);
      seg(1, 1, 3);
      check("off1_locked", int'(locked), 1);
      seg(1, 50, 3);
      seg(0, 1, 3);
      check("off2_locked", int'(locked), 0);
      check("off_count", got_q.size(), 2);
      check("off_bit0", int'(got_q[0]), 1);
      check("off_bit1", int'(got_q[1]), 0);
      got_q.delete();
      seg(0, 99, 3); seg(1, 100, 3); seg(0, 100, 3); seg(1, 100, 3);
      check("acq_no_strobe", got_q.size(), 0);
      check("acq_locked", int'(locked), 0);
      seg(0, 1, 3);
      check("relock", int'(locked), 1);
      check("relock_no_strobe", got_q.size(), 0);

      // Reset mid-UI at ph=37 while locked
      seg(0, 99, 3); seg(1, 100, 3); seg(0, 38, 3);
      check("pre_rst_locked", int'(locked), 1);
      check("pre_rst_bit", int'(bit_out), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_locked", int'(locked), 0);
      check("mid_rst_bit_out", int'(bit_out), 0);
      check("mid_rst_bit_valid", int'(bit_valid), 0);
      check("mid_rst_slope_dir", int'(slope_dir), 0);
      #1 rst_n = 1'b1;

      // Restart from IDLE: same lock sequence as after power-up
      cur_lvl = 0;
      got_q.delete();
      seg(1, 100, 1); seg(0, 100, 1); seg(1, 100, 1); seg(0, 100, 1);
      check("restart_pre", int'(locked), 0);
      seg(1, 1 + LAG, 1);
      check("restart_lock", int'(locked), 1);
      check("restart_no_strobe", got_q.size(), 0);

      // Rising ramp with a single -1 LSB dip
      seg(1, 30, 1);
      cur_lvl = cur_lvl - 1;
      step(cur_lvl, 1'b1);
      check("dip_dir", int'(slope_dir), (LAG != 0) ? 1 : 0);
      seg(1, 1, 1);
      check("dip_recover_dir", int'(slope_dir), 1);
      check("dip_locked", int'(locked), 1);
      got_q.delete(); strobe_cyc.delete();
      base_cyc = cyc;
      seg(1, 100, 1);
      check("dip_count", got_q.size(), 1);
      check("dip_strobe_at", strobe_cyc[0] - base_cyc, (LAG != 0) ? 68 : 100);
      check("dip_bit", int'(got_q[0]), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
